// File: rtl/fmul_pipe.sv
// fmul_pipe: 3-stage pipelined floating-point multiplier with valid/ready flow control.
//   S1 unpacks and classifies the operands.
//   S2 multiplies the mantissas and adds the exponents.
//   S3 normalises, rounds and packs the result into the output register.
// Configuration macro: FMUL_PIPE_RNE_EN. When defined, results are rounded to
// nearest-even. When undefined, results are truncated toward zero.
// Inputs with a zero exponent field are flushed to zero. The sign is kept.
module fmul_pipe #(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic [EXP_W+FRAC_W:0]   iA,
  input  logic [EXP_W+FRAC_W:0]   iB,
  output logic                    oValid,
  input  logic                    iReady,
  output logic [EXP_W+FRAC_W:0]   oProd,
  output logic [3:0]              oFlags
);

  localparam int F  = FRAC_W;
  localparam int PW = 2*FRAC_W + 2;   // full mantissa product width
  localparam int XW = EXP_W + 2;      // signed exponent working width
  localparam logic [XW-1:0] BIAS     = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [XW-1:0] EXP_ONES = {2'b00, {EXP_W{1'b1}}};

  typedef enum logic [1:0] {CL_NORM, CL_ZERO, CL_INF, CL_NAN} cls_e;

  // stage valid bits and output registers
  logic                  v1_q, v2_q, v3_q;
  logic [EXP_W+FRAC_W:0] prod_q;
  logic [3:0]            flags_q;

  // global pipeline advance: every stage moves together
  logic adv;
  assign adv    = !v3_q || iReady;
  assign oReady = adv;
  assign oValid = v3_q;
  assign oProd  = prod_q;
  assign oFlags = flags_q;

  // S1 combinational: operand field extraction and joint special-case class
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [F-1:0]     a_frac, b_frac;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  cls_e             cls_d;

  // classify the operand pair into one result class
  always_comb begin
    a_exp  = iA[EXP_W+F-1:F];
    b_exp  = iB[EXP_W+F-1:F];
    a_frac = iA[F-1:0];
    b_frac = iB[F-1:0];
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_inf  = (&a_exp) && (a_frac == '0);
    b_inf  = (&b_exp) && (b_frac == '0);
    a_nan  = (&a_exp) && (|a_frac);
    b_nan  = (&b_exp) && (|b_frac);
    cls_d  = CL_NORM;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      cls_d = CL_NAN;
    else if (a_inf || b_inf)
      cls_d = CL_INF;
    else if (a_zero || b_zero)
      cls_d = CL_ZERO;
  end

  // S1/S2 datapath registers (no reset, qualified by the valid bits)
  logic             s1_sign_q, s2_sign_q;
  logic [EXP_W-1:0] s1_exp_a_q, s1_exp_b_q;
  logic [F:0]       s1_man_a_q, s1_man_b_q;
  cls_e             s1_cls_q, s2_cls_q;
  logic [PW-1:0]    s2_prod_q;
  logic [XW-1:0]    s2_exp_q;

  // S1 capture and S2 multiply / exponent add
  always_ff @(posedge iCLK) begin
    if (adv) begin
      s1_sign_q  <= iA[EXP_W+F] ^ iB[EXP_W+F];
      s1_exp_a_q <= a_exp;
      s1_exp_b_q <= b_exp;
      s1_man_a_q <= {1'b1, a_frac};
      s1_man_b_q <= {1'b1, b_frac};
      s1_cls_q   <= cls_d;
      s2_sign_q  <= s1_sign_q;
      s2_cls_q   <= s1_cls_q;
      s2_prod_q  <= {{(F+1){1'b0}}, s1_man_a_q} * {{(F+1){1'b0}}, s1_man_b_q};
      s2_exp_q   <= {2'b00, s1_exp_a_q} + {2'b00, s1_exp_b_q} - BIAS;
    end
  end

  // S3 combinational: normalise, round and pack
  logic          norm, guard, sticky, round_up, inexact, ovf, unf;
  logic [F-1:0]  frac_t, frac_f;
  logic [F:0]    frac_r;
  logic [XW-1:0] exp_n, exp_f;
  logic [EXP_W+FRAC_W:0] res_prod_d;
  logic [3:0]            res_flags_d;

  // normalisation by at most one place, then rounding and range checks
  always_comb begin
    norm = s2_prod_q[PW-1];
    if (norm) begin
      frac_t = s2_prod_q[PW-2:F+1];
      guard  = s2_prod_q[F];
      sticky = |s2_prod_q[F-1:0];
    end else begin
      frac_t = s2_prod_q[PW-3:F];
      guard  = s2_prod_q[F-1];
      sticky = |s2_prod_q[F-2:0];
    end
    exp_n = s2_exp_q + {{(XW-1){1'b0}}, norm};
`ifdef FMUL_PIPE_RNE_EN
    round_up = guard && (sticky || frac_t[0]);
`else
    round_up = 1'b0;
`endif
    frac_r  = {1'b0, frac_t} + {{F{1'b0}}, round_up};
    exp_f   = exp_n + {{(XW-1){1'b0}}, frac_r[F]};
    frac_f  = frac_r[F] ? '0 : frac_r[F-1:0];
    inexact = guard || sticky;
    ovf     = !exp_f[XW-1] && (exp_f >= EXP_ONES);
    unf     = exp_f[XW-1] || (exp_f == '0);

    res_prod_d  = '0;
    res_flags_d = '0;
    case (s2_cls_q)
      CL_NAN: begin
        res_prod_d  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(F-1){1'b0}}};
        res_flags_d = 4'b1000;
      end
      CL_INF:  res_prod_d = {s2_sign_q, {EXP_W{1'b1}}, {F{1'b0}}};
      CL_ZERO: res_prod_d = {s2_sign_q, {(EXP_W+F){1'b0}}};
      default: begin
        if (ovf) begin
          res_prod_d  = {s2_sign_q, {EXP_W{1'b1}}, {F{1'b0}}};
          res_flags_d = 4'b0101;
        end else if (unf) begin
          res_prod_d  = {s2_sign_q, {(EXP_W+F){1'b0}}};
          res_flags_d = 4'b0011;
        end else begin
          res_prod_d  = {s2_sign_q, exp_f[EXP_W-1:0], frac_f};
          res_flags_d = {3'b000, inexact};
        end
      end
    endcase
  end

  // valid bits and output register, cleared immediately by reset
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      prod_q  <= '0;
      flags_q <= '0;
    end else if (adv) begin
      v1_q <= iValid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (v2_q) begin
        prod_q  <= res_prod_d;
        flags_q <= res_flags_d;
      end
    end
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: directed and randomized checks of fmul_pipe (EXP_W=11, FRAC_W=52)
// against an arithmetic reference model, using a scoreboard queue of expected results.
module tb_fmul_pipe;

  logic        iCLK, iRST_N, iValid, oReady, oValid, iReady;
  logic [63:0] iA, iB, oProd;
  logic [3:0]  oFlags;

  fmul_pipe dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iValid(iValid), .oReady(oReady),
    .iA(iA), .iB(iB), .oValid(oValid), .iReady(iReady),
    .oProd(oProd), .oFlags(oFlags)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int          total = 0;
  int          bad   = 0;
  logic [67:0] exp_q[$];
  logic        held = 1'b0;
  logic [67:0] held_val = '0;
  logic        last_ov = 1'b0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer product, rounded by remainder comparison
  function automatic logic [67:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    logic         s, inexact;
    int           ea, eb, e, sh;
    logic [51:0]  fa, fb;
    logic [105:0] m, rem, half;
    logic [53:0]  kept;
    bit           za, zb, ia, ib, na, nb;
    s  = a[63] ^ b[63];
    ea = int'(a[62:52]); eb = int'(b[62:52]);
    fa = a[51:0];        fb = b[51:0];
    za = (ea == 0);      zb = (eb == 0);
    ia = (ea == 2047) && (fa == 0); ib = (eb == 2047) && (fb == 0);
    na = (ea == 2047) && (fa != 0); nb = (eb == 2047) && (fb != 0);
    if (na || nb || (ia && zb) || (za && ib)) return {4'b1000, 64'h7FF8000000000000};
    if (ia || ib) return {4'b0000, s, 11'h7FF, 52'h0};
    if (za || zb) return {4'b0000, s, 63'h0};
    m = {53'h0, 1'b1, fa} * {53'h0, 1'b1, fb};
    e = ea + eb - 1023;
    if (m >= (106'd1 << 105)) begin sh = 53; e++; end
    else sh = 52;
    kept    = 54'(m >> sh);
    rem     = m & ((106'd1 << sh) - 106'd1);
    half    = 106'd1 << (sh - 1);
    inexact = (rem != 0);
`ifdef FMUL_PIPE_RNE_EN
    if (rem > half || (rem == half && kept[0])) kept++;
`endif
    if (kept == (54'd1 << 53)) begin kept = kept >> 1; e++; end
    if (e >= 2047) return {4'b0101, s, 11'h7FF, 52'h0};
    if (e <= 0)    return {4'b0011, s, 63'h0};
    return {3'b000, inexact, s, 11'(e), kept[51:0]};
  endfunction

  function automatic logic [63:0] rnd_op();
    logic [63:0] r;
    int k;
    r = {$urandom, $urandom};
    k = int'($urandom_range(0, 9));
    case (k)
      0: r[62:52] = 11'h000;
      1: begin
        r[62:52] = 11'h7FF;
        if ($urandom_range(0, 1) == 0) r[51:0] = 52'h0;
      end
      2, 3: ;
      4: r[62:52] = ($urandom_range(0, 1) == 0) ? 11'(1 + $urandom_range(0, 30))
                                                 : 11'(2046 - $urandom_range(0, 30));
      5: begin
        r[62:52] = 11'(1003 + $urandom_range(0, 40));
        r[40:0]  = 41'h0;
      end
      default: r[62:52] = 11'(1003 + $urandom_range(0, 40));
    endcase
    return r;
  endfunction

  // One cycle: drive at negedge, check outputs, track handshake, wait next negedge
  task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b,
                      input logic rdy, input logic [67:0] expv);
    iValid = v; iA = a; iB = b; iReady = rdy;
    #1;
    last_ov = oValid;
    if (held) chk("stall_hold", 72'({oValid, oFlags, oProd}), 72'({1'b1, held_val}));
    chk("oready", 72'(oReady), 72'(!oValid || rdy));
    if (oValid && rdy) begin
      if (exp_q.size() == 0) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL spurious_out: got result %h want none pending", oProd);
        end
      end else begin
        chk("result", 72'({oFlags, oProd}), 72'(exp_q.pop_front()));
      end
    end
    held     = oValid && !rdy;
    held_val = {oFlags, oProd};
    if (v && oReady) exp_q.push_back(expv);
    @(negedge iCLK);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step(1'b0, 64'h0, 64'h0, 1'b1, 68'h0);
      n++;
    end
    chk("pending_left", 72'(exp_q.size()), 72'd0);
  endtask

  initial begin
    logic [63:0] a, b;
    logic        v, r;
    iRST_N = 1'b0; iValid = 1'b0; iReady = 1'b1; iA = '0; iB = '0;
    repeat (2) @(negedge iCLK);
    #1;
    chk("rst_ovalid", 72'(oValid), 72'd0);
    chk("rst_oprod",  72'(oProd),  72'd0);
    chk("rst_oflags", 72'(oFlags), 72'd0);
    @(negedge iCLK);
    iRST_N = 1'b1;

    // 7.0 * -9.0 with latency check
    step(1'b1, 64'h401C000000000000, 64'hC022000000000000, 1'b1, {4'b0000, 64'hC04F800000000000});
    step(1'b0, 64'h0, 64'h0, 1'b1, 68'h0);
    chk("lat_c1", 72'(last_ov), 72'd0);
    step(1'b0, 64'h0, 64'h0, 1'b1, 68'h0);
    chk("lat_c2", 72'(last_ov), 72'd0);
    step(1'b0, 64'h0, 64'h0, 1'b1, 68'h0);
    chk("lat_c3", 72'(last_ov), 72'd1);

    // rounding, overflow, invalid, underflow
`ifdef FMUL_PIPE_RNE_EN
    step(1'b1, 64'h3FF0000000000001, 64'h3FF8000000000000, 1'b1, {4'b0001, 64'h3FF8000000000002});
`else
    step(1'b1, 64'h3FF0000000000001, 64'h3FF8000000000000, 1'b1, {4'b0001, 64'h3FF8000000000001});
`endif
    step(1'b1, 64'h7FE0000000000000, 64'h4000000000000000, 1'b1, {4'b0101, 64'h7FF0000000000000});
    step(1'b1, 64'h7FF0000000000000, 64'h0000000000000000, 1'b1, {4'b1000, 64'h7FF8000000000000});
    step(1'b1, 64'h0010000000000000, 64'h3FE0000000000000, 1'b1, {4'b0011, 64'h0000000000000000});
    step(1'b1, 64'hFFF0000000000000, 64'h4000000000000000, 1'b1, {4'b0000, 64'hFFF0000000000000});
    step(1'b1, 64'h8000000000000000, 64'h4000000000000000, 1'b1, {4'b0000, 64'h8000000000000000});
    drain();

    // 4 back-to-back operations followed by a 5-cycle output stall
    for (int i = 0; i < 4; i++) begin
      a = rnd_op(); b = 64'h4008000000000000;
      step(1'b1, a, b, 1'b1, ref_mul(a, b));
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 64'h0, 64'h0, 1'b0, 68'h0);
      chk("stall_oready", 72'(oReady), 72'd0);
    end
    drain();

    // reset with 3 operations in flight
    for (int i = 0; i < 3; i++) begin
      a = rnd_op(); b = rnd_op();
      step(1'b1, a, b, 1'b1, ref_mul(a, b));
    end
    iValid = 1'b0;
    iRST_N = 1'b0;
    #1;
    chk("midrst_ovalid", 72'(oValid), 72'd0);
    chk("midrst_oprod",  72'(oProd),  72'd0);
    chk("midrst_oflags", 72'(oFlags), 72'd0);
    exp_q.delete();
    held = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    #1;
    chk("post_rst_oready", 72'(oReady), 72'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 64'h0, 64'h0, 1'b1, 68'h0);
      chk("no_stale", 72'(last_ov), 72'd0);
    end

    // randomized traffic with random bubbles and back-pressure
    for (int i = 0; i < 400; i++) begin
      a = rnd_op(); b = rnd_op();
      v = ($urandom_range(0, 9) < 8);
      r = ($urandom_range(0, 3) != 0);
      step(v, a, b, r, ref_mul(a, b));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
